mult24_seq_ctrl: RTL and testbench

//   Sequential shift-add multiplier controller built around one pp24 partial-product row.

---
 rtl/mult24_seq_ctrl_pkg.sv | 19 +
 rtl/mult24_seq_ctrl_if.sv | 32 +++
 rtl/mult24_seq_ctrl_pp24.sv | 20 ++
 rtl/mult24_seq_ctrl.sv | 110 +++++++++++
 tb/tb_mult24_seq_ctrl.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/mult24_seq_ctrl_pkg.sv
// ============================================================================
// Module : mult_pkg
// Brief  : Shared width constants and FSM encoding for the 24-bit shift-add multiplier.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mult_pkg;
   localparam int W     = 24;
   localparam int CNT_W = $clog2(W);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;
endpackage

`default_nettype wire

// File: rtl/mult24_seq_ctrl_if.sv
// ============================================================================
// Module : mult24_seq_ctrl_if
// Brief  : Operand/product handshake bundle for the sequential multiplier.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface mult24_seq_ctrl_if;
   import mult_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     a;
   logic [W-1:0]     b;
   logic             clear;
   logic             busy;
   logic             out_valid;
   logic             out_ready;
   logic [2*W-1:0]   product;

   modport master (
      output in_valid, a, b, clear, out_ready,
      input  in_ready, busy, out_valid, product
   );

   modport slave (
      input  in_valid, a, b, clear, out_ready,
      output in_ready, busy, out_valid, product
   );
endinterface

`default_nettype wire

// File: rtl/mult24_seq_ctrl_pp24.sv
// ============================================================================
// Module : pp24
// Brief  : One partial-product row: multiplicand gated by a single multiplier bit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pp24 #(
   parameter int W = 24
) (
   input  logic [W-1:0] a,
   input  logic         sel,
   output logic [W-1:0] row
);
   for (genvar i = 0; i < W; i++) begin : g_bit
      assign row[i] = a[i] & sel;
   end
endmodule

`default_nettype wire

// File: rtl/mult24_seq_ctrl.sv
// ============================================================================
// Module : mult24_seq_ctrl
// Brief  : Sequential LSB-first shift-add 24x24 unsigned multiplier controller.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mult24_seq_ctrl
   import mult_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   mult24_seq_ctrl_if.slave  bus
);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(W - 1);

   state_t             state;
   state_t             state_nx;
   logic [W-1:0]       a_reg;
   logic [W-1:0]       hi;
   logic [W-1:0]       lo;
   logic [W-1:0]       row;
   logic [W:0]         sum;
   logic [CNT_W-1:0]   cnt;
   logic               load;
   logic               step;

   pp24 #(.W(W)) u_pp24 (
      .a   (a_reg),
      .sel (lo[0]),
      .row (row)
   );

   // Carry out of the add lands in hi's MSB when the accumulator shifts right.
   assign sum = {1'b0, hi} + {1'b0, row};

   // Product is only exposed in DONE so no partial accumulation leaks out.
   assign bus.product = (state == DONE) ? {hi, lo} : '0;

   always_comb begin
      state_nx      = state;
      bus.in_ready  = 1'b0;
      bus.busy      = 1'b0;
      bus.out_valid = 1'b0;
      load          = 1'b0;
      step          = 1'b0;
      case (state)
         IDLE: begin
            bus.in_ready = !bus.clear;
            if (bus.in_valid && !bus.clear) begin
               load     = 1'b1;
               state_nx = RUN;
            end
         end
         RUN: begin
            bus.busy = 1'b1;
            step     = !bus.clear;
            if (cnt == LAST_CNT) begin
               state_nx = DONE;
            end
         end
         DONE: begin
            bus.out_valid = 1'b1;
            bus.in_ready  = bus.out_ready && !bus.clear;
            if (bus.out_ready) begin
               if (bus.in_valid) begin
                  load     = !bus.clear;
                  state_nx = RUN;
               end else begin
                  state_nx = IDLE;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
      if (bus.clear) begin
         state_nx = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg <= '0;
         hi    <= '0;
         lo    <= '0;
         cnt   <= '0;
      end else if (bus.clear) begin
         cnt <= '0;
      end else if (load) begin
         a_reg <= bus.a;
         hi    <= '0;
         lo    <= bus.b;
         cnt   <= '0;
      end else if (step) begin
         hi  <= sum[W:1];
         lo  <= {sum[0], lo[W-1:1]};
         cnt <= cnt + CNT_W'(1);
      end
   end
endmodule

`default_nettype wire

// File: tb/tb_mult24_seq_ctrl.sv
// ============================================================================
// Module : tb_mult24_seq_ctrl
// Brief  : Scoreboard bench for mult24_seq_ctrl using hand-computed products.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_mult24_seq_ctrl;
   import mult_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   mult24_seq_ctrl_if bus ();

   mult24_seq_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int          tests = 0;
   int          fails = 0;
   int          cyc   = 0;
   int          acc_cyc;
   int          acc_first;
   logic [47:0] exp_q [$];
   int          rise_q [$];
   logic        prev_ov = 1'b0;
   logic [47:0] mon_exp;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: pops an expected product on every output handshake.
   always @(negedge clk) begin
      if (rst_n && bus.out_valid && !prev_ov) rise_q.push_back(cyc);
      if (rst_n && bus.out_valid && bus.out_ready) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL scoreboard: got unexpected product %h, required none", bus.product);
         end else begin
            mon_exp = exp_q.pop_front();
            if (bus.product !== mon_exp) begin
               fails++;
               $display("FAIL scoreboard: product got %h required %h", bus.product, mon_exp);
            end
         end
      end
      prev_ov = rst_n & bus.out_valid;
   end

   task automatic check(input string name, input logic [47:0] act, input logic [47:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [23:0] x, input logic [23:0] y, input logic [47:0] e,
                       input bit push, input bit hold);
      int n;
      bus.a        = x;
      bus.b        = y;
      bus.in_valid = 1'b1;
      #1;
      n = 0;
      while (!bus.in_ready && n < 100) begin
         tick();
         n++;
      end
      if (!bus.in_ready) begin
         check("send_timeout", 48'd0, 48'd1);
      end else begin
         if (push) exp_q.push_back(e);
         acc_cyc = cyc + 1;
         tick();
      end
      if (!hold) bus.in_valid = 1'b0;
   endtask

   task automatic drain(input int max);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < max) begin
         tick();
         n++;
      end
      check("drain_done", 48'(exp_q.size()), 48'd0);
      tick();
   endtask

   task automatic wait_ov(input int max);
      int n;
      n = 0;
      while (!bus.out_valid && n < max) begin
         tick();
         n++;
      end
      check("wait_out_valid", 48'(bus.out_valid), 48'd1);
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.clear     = 1'b0;
      bus.out_ready = 1'b1;

      // Reset state
      #12;
      check("rst_busy", 48'(bus.busy), 48'd0);
      check("rst_out_valid", 48'(bus.out_valid), 48'd0);
      check("rst_product", bus.product, 48'd0);
      #10 rst_n = 1'b1;
      tick();
      check("idle_in_ready", 48'(bus.in_ready), 48'd1);
      check("idle_busy", 48'(bus.busy), 48'd0);

      // 1: 3*5 with latency check
      rise_q.delete();
      send(24'd3, 24'd5, 48'h00000000000F, 1'b1, 1'b0);
      drain(60);
      check("t1_rises", 48'(rise_q.size()), 48'd1);
      check("t1_latency", (rise_q.size() > 0) ? 48'(rise_q[0] - acc_cyc) : 48'hFFFF, 48'd24);

      // 2: extremes and zeros
      send(24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, 1'b1, 1'b0);
      send(24'h000000, 24'h123456, 48'h000000000000, 1'b1, 1'b0);
      send(24'hABCDEF, 24'h000000, 48'h000000000000, 1'b1, 1'b0);
      send(24'h123456, 24'h000100, 48'h000012345600, 1'b1, 1'b0);
      drain(200);

      // 3: hold in DONE with out_ready low
      bus.out_ready = 1'b0;
      send(24'd5, 24'd5, 48'd25, 1'b1, 1'b0);
      wait_ov(60);
      for (int i = 0; i < 10; i++) begin
         check("t3_hold_valid", 48'(bus.out_valid), 48'd1);
         check("t3_hold_product", bus.product, 48'd25);
         check("t3_hold_in_ready", 48'(bus.in_ready), 48'd0);
         tick();
      end
      bus.out_ready = 1'b1;
      tick();
      check("t3_idle_valid", 48'(bus.out_valid), 48'd0);
      check("t3_idle_in_ready", 48'(bus.in_ready), 48'd1);
      check("t3_idle_busy", 48'(bus.busy), 48'd0);
      check("t3_sb_empty", 48'(exp_q.size()), 48'd0);

      // 4: back-to-back with in_valid held
      rise_q.delete();
      send(24'd7, 24'd9, 48'd63, 1'b1, 1'b1);
      acc_first = acc_cyc;
      send(24'h800000, 24'd2, 48'h000001000000, 1'b1, 1'b0);
      drain(80);
      check("t4_rises", 48'(rise_q.size()), 48'd2);
      if (rise_q.size() == 2) begin
         check("t4_latency", 48'(rise_q[0] - acc_first), 48'd24);
         check("t4_spacing", 48'(rise_q[1] - rise_q[0]), 48'd25);
      end

      // 5: clear in RUN drops the op
      rise_q.delete();
      send(24'd9, 24'd9, 48'd81, 1'b0, 1'b0);
      repeat (9) tick();
      bus.clear = 1'b1;
      #1;
      check("t5_clear_in_ready", 48'(bus.in_ready), 48'd0);
      check("t5_busy_before", 48'(bus.busy), 48'd1);
      tick();
      bus.clear = 1'b0;
      #1;
      check("t5_busy_after", 48'(bus.busy), 48'd0);
      check("t5_valid_after", 48'(bus.out_valid), 48'd0);
      check("t5_in_ready_after", 48'(bus.in_ready), 48'd1);
      repeat (40) tick();
      check("t5_no_output", 48'(rise_q.size()), 48'd0);
      send(24'd6, 24'd7, 48'd42, 1'b1, 1'b0);
      drain(60);

      // 6: asynchronous reset mid-run
      send(24'd5, 24'd5, 48'd25, 1'b0, 1'b0);
      repeat (12) tick();
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_busy", 48'(bus.busy), 48'd0);
      check("t6_rst_valid", 48'(bus.out_valid), 48'd0);
      check("t6_rst_product", bus.product, 48'd0);
      tick();
      rst_n = 1'b1;
      tick();
      check("t6_post_busy", 48'(bus.busy), 48'd0);
      check("t6_post_in_ready", 48'(bus.in_ready), 48'd1);
      send(24'd11, 24'd13, 48'd143, 1'b1, 1'b0);
      drain(60);

      check("final_sb_empty", 48'(exp_q.size()), 48'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

`default_nettype wire
